// File: rtl/spi_flash_responder.sv
// spi_flash_responder: device-side SPI flash emulator (mode 0, oversampled by wb_clk_i).
// Answers READ (0x03) from an internal byte array, JEDEC ID (0x9F) with a
// rotating 3-byte ID, and ignores everything else (including 0xAB) until CS rises.
// Optional macro SPI_FLASH_RESPONDER_FAST_READ_EN adds FAST READ (0x0B) with
// 8 dummy clocks between address and data.
// Ports:
//   wb_clk_i, wb_rst_n_i      : clock, async active-low reset
//   i_spi_cs_n/clk/mosi       : SPI inputs (asynchronous, synchronized here)
//   o_spi_miso                : SPI data out, changes on detected SCK fall
//   i_mem_we/adr/dat          : preload write port into the byte array
//   o_busy                    : synchronized chip-select active
//   o_cmd_stb, o_cmd          : opcode-complete pulse and last opcode
module spi_flash_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              i_spi_cs_n,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  output logic              o_spi_miso,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_adr,
  input  logic [7:0]        i_mem_dat,
  output logic              o_busy,
  output logic              o_cmd_stb,
  output logic [7:0]        o_cmd
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  localparam logic [2:0] ST_DUMMY  = 3'd3;
`endif
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_ID     = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  logic [2:0]        state, state_nxt;
  logic              cs_s1, cs_s2;
  logic              sck_s1, sck_s2, sck_s3;
  logic              mosi_s1, mosi_s2;
  logic [4:0]        bit_cnt;
  logic [6:0]        cmd_sr;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        tx_sr;
  logic [7:0]        nxt_byte;
  logic [2:0]        tx_cnt;
  logic              load_pend;
  logic [23:0]       id_sr;
  logic [7:0]        mem [DEPTH];

  logic              rise_c, fall_c, entering_c;
  logic [7:0]        opcode_c;
  logic [ADDR_W-1:0] addr_inc_c;

  // SCK edges only count while CS is asserted
  assign rise_c     = sck_s2 & ~sck_s3 & ~cs_s2;
  assign fall_c     = ~sck_s2 & sck_s3 & ~cs_s2;
  assign entering_c = (state_nxt != state);
  assign opcode_c   = {cmd_sr, mosi_s2};
  assign addr_inc_c = addr + ADDR_W'(1);

  // Input synchronizers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      cs_s1   <= i_spi_cs_n;
      cs_s2   <= cs_s1;
      sck_s1  <= i_spi_clk;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      mosi_s1 <= i_spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state logic; CS release wins over everything
  always_comb begin
    state_nxt = state;
    if (state != ST_IDLE && cs_s2) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!cs_s2) state_nxt = ST_CMD;
        ST_CMD: begin
          if (rise_c && bit_cnt == 5'd7) begin
            case (opcode_c)
              8'h03:   state_nxt = ST_ADDR;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
              8'h0B:   state_nxt = ST_ADDR;
`endif
              8'h9F:   state_nxt = ST_ID;
              default: state_nxt = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: begin
          if (rise_c && bit_cnt == 5'd23) begin
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            state_nxt = (o_cmd == 8'h0B) ? ST_DUMMY : ST_DATA;
`else
            state_nxt = ST_DATA;
`endif
          end
        end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        ST_DUMMY: if (rise_c && bit_cnt == 5'd7) state_nxt = ST_DATA;
`endif
        ST_DATA:   state_nxt = ST_DATA;
        ST_ID:     state_nxt = ST_ID;
        ST_IGNORE: state_nxt = ST_IGNORE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shift/count datapath and registered outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      bit_cnt    <= '0;
      cmd_sr     <= '0;
      addr       <= '0;
      tx_sr      <= 8'hFF;
      nxt_byte   <= 8'hFF;
      tx_cnt     <= '0;
      load_pend  <= 1'b0;
      id_sr      <= JEDEC_ID;
      o_spi_miso <= 1'b1;
      o_busy     <= 1'b0;
      o_cmd_stb  <= 1'b0;
      o_cmd      <= 8'h00;
    end else begin
      o_busy    <= ~cs_s2;
      o_cmd_stb <= 1'b0;

      if (entering_c)  bit_cnt <= '0;
      else if (rise_c) bit_cnt <= bit_cnt + 5'd1;

      if (state == ST_CMD && rise_c) begin
        cmd_sr <= opcode_c[6:0];
        if (bit_cnt == 5'd7) begin
          o_cmd     <= opcode_c;
          o_cmd_stb <= 1'b1;
        end
      end

      // Address shifts straight into addr; bits above ADDR_W fall off the top
      if (state == ST_ADDR && rise_c) addr <= {addr[ADDR_W-2:0], mosi_s2};

      if (entering_c && state_nxt == ST_DATA) load_pend <= 1'b1;
      if (entering_c && state_nxt == ST_ID)   id_sr     <= JEDEC_ID;

      if (entering_c) begin
        o_spi_miso <= 1'b1;
      end else if (state == ST_DATA) begin
        if (load_pend) begin
          tx_sr     <= mem[addr];
          tx_cnt    <= '0;
          load_pend <= 1'b0;
        end else if (fall_c) begin
          o_spi_miso <= tx_sr[7];
          tx_cnt     <= tx_cnt + 3'd1;
          // Prefetch the following byte as bit7 of the current one goes out
          if (tx_cnt == 3'd0) begin
            nxt_byte <= mem[addr_inc_c];
            addr     <= addr_inc_c;
          end
          if (tx_cnt == 3'd7) tx_sr <= nxt_byte;
          else                tx_sr <= {tx_sr[6:0], 1'b1};
        end
      end else if (state == ST_ID) begin
        if (fall_c) begin
          o_spi_miso <= id_sr[23];
          id_sr      <= {id_sr[22:0], id_sr[23]};
        end
      end else begin
        o_spi_miso <= 1'b1;
      end
    end
  end

  // Preload port; array is intentionally not reset
  always_ff @(posedge wb_clk_i) begin
    if (i_mem_we) mem[i_mem_adr] <= i_mem_dat;
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed bench for spi_flash_responder.
// SCK runs at clk/4; inputs change on the falling clk edge.
module tb_spi_flash_responder;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cs_n, sck, mosi, miso;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [7:0]        mem_dat;
  logic              busy, cmd_stb;
  logic [7:0]        cmd;

  int tests = 0;
  int fails = 0;
  int stb_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_stb === 1'b1) stb_cnt++;

  spi_flash_responder #(.DEPTH(DEPTH), .JEDEC_ID(24'hEF4016)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .i_spi_cs_n (cs_n),
    .i_spi_clk  (sck),
    .i_spi_mosi (mosi),
    .o_spi_miso (miso),
    .i_mem_we   (mem_we),
    .i_mem_adr  (mem_adr),
    .i_mem_dat  (mem_dat),
    .o_busy     (busy),
    .o_cmd_stb  (cmd_stb),
    .o_cmd      (cmd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    mem_we = 1'b1; mem_adr = a; mem_dat = d;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  // One SCK period: fall (mosi changes), rise, then sample what the fall drove
  task automatic sck_bit(input logic b, output logic s);
    sck = 1'b0; mosi = b;
    repeat (2) @(negedge clk);
    sck = 1'b1;
    repeat (2) @(negedge clk);
    s = miso;
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) sck_bit(v[i], s);
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(1'b0, s);
      v[i] = s;
    end
  endtask

  task automatic start_xfer();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic stop_xfer();
    sck = 1'b0;
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_read(input logic [7:0] op, input logic [23:0] a);
    send_byte(op);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  initial begin
    logic [7:0] b;
    logic       s;
    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    mem_we = 1'b0; mem_adr = '0; mem_dat = '0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stb",  32'(cmd_stb), 32'h0);
    check("rst_cmd",  32'(cmd), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    wr(10'd0, 8'hA5); wr(10'd1, 8'h5A); wr(10'd2, 8'h01); wr(10'd3, 8'h80);
    wr(10'd1023, 8'h3C);

    // READ from 0, four bytes
    stb_cnt = 0;
    start_xfer();
    check("busy_on", 32'(busy), 32'h1);
    send_read(8'h03, 24'h000000);
    recv_byte(b); check("rd0_b0", 32'(b), 32'hA5);
    recv_byte(b); check("rd0_b1", 32'(b), 32'h5A);
    recv_byte(b); check("rd0_b2", 32'(b), 32'h01);
    recv_byte(b); check("rd0_b3", 32'(b), 32'h80);
    stop_xfer();
    check("rd0_stb_cnt", 32'(stb_cnt), 32'd1);
    check("rd0_cmd", 32'(cmd), 32'h03);
    check("rd0_busy_off", 32'(busy), 32'h0);
    check("rd0_miso_idle", 32'(miso), 32'h1);

    // Wrap at DEPTH-1
    start_xfer();
    send_read(8'h03, 24'h0003FF);
    recv_byte(b); check("wrap_b0", 32'(b), 32'h3C);
    recv_byte(b); check("wrap_b1", 32'(b), 32'hA5);
    stop_xfer();

    // Upper address bits ignored
    start_xfer();
    send_read(8'h03, 24'h0403FF);
    recv_byte(b); check("hiaddr_b0", 32'(b), 32'h3C);
    stop_xfer();

    // JEDEC ID repeats after three bytes
    start_xfer();
    send_byte(8'h9F);
    recv_byte(b); check("id_b0", 32'(b), 32'hEF);
    recv_byte(b); check("id_b1", 32'(b), 32'h40);
    recv_byte(b); check("id_b2", 32'(b), 32'h16);
    recv_byte(b); check("id_b3", 32'(b), 32'hEF);
    recv_byte(b); check("id_b4", 32'(b), 32'h40);
    recv_byte(b); check("id_b5", 32'(b), 32'h16);
    stop_xfer();
    check("id_cmd", 32'(cmd), 32'h9F);

    // Unknown opcode: miso held high
    start_xfer();
    send_byte(8'h55);
    recv_byte(b); check("ign_b0", 32'(b), 32'hFF);
    recv_byte(b); check("ign_b1", 32'(b), 32'hFF);
    check("ign_cmd", 32'(cmd), 32'h55);
    stop_xfer();

    // CS released mid-byte, then a fresh READ
    start_xfer();
    send_read(8'h03, 24'h000000);
    recv_byte(b); check("abort_b0", 32'(b), 32'hA5);
    for (int i = 0; i < 4; i++) sck_bit(1'b0, s);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_miso", 32'(miso), 32'h1);
    sck = 1'b0;
    repeat (6) @(negedge clk);
    start_xfer();
    send_read(8'h03, 24'h000002);
    recv_byte(b); check("after_abort_b0", 32'(b), 32'h01);
    stop_xfer();

    // FAST READ with 8 dummy clocks
    start_xfer();
    send_read(8'h0B, 24'h000001);
    send_byte(8'h00);
    recv_byte(b);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    check("fast_b0", 32'(b), 32'h5A);
`else
    check("fast_b0", 32'(b), 32'hFF);
`endif
    recv_byte(b);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    check("fast_b1", 32'(b), 32'h01);
`else
    check("fast_b1", 32'(b), 32'hFF);
`endif
    check("fast_cmd", 32'(cmd), 32'h0B);
    stop_xfer();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
